// File: rtl/cascade_updown_timer.sv
// Cascaded modulo up/down counter chain, stage 0 least significant.
// Supports parallel load, per-stage adjust and wrap/saturate behaviour at the chain limits.
module cascade_updown_timer #(
  parameter int                          NUM_STAGES = 3,
  parameter int                          WIDTH      = 6,
  parameter logic [NUM_STAGES*WIDTH-1:0] MAX_VEC    = {6'd23, 6'd59, 6'd59},
  parameter int                          WRAP_MODE  = 1,
  parameter int                          SEL_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tick,
  input  logic                          up_down,
  input  logic                          load,
  input  logic [NUM_STAGES*WIDTH-1:0]   load_val,
  input  logic                          adj_en,
  input  logic [SEL_W-1:0]              adj_stage,
  output logic [NUM_STAGES*WIDTH-1:0]   count,
  output logic                          carry_out,
  output logic                          at_zero,
  output logic                          at_max
);

  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

  if (NUM_STAGES < 1 || WIDTH < 1) begin : g_bad_params
    $error("cascade_updown_timer: NUM_STAGES and WIDTH must be at least 1");
  end

  logic [WIDTH-1:0] cnt_q   [NUM_STAGES];
  logic [WIDTH-1:0] cnt_d   [NUM_STAGES];
  logic [WIDTH-1:0] max_s   [NUM_STAGES];
  logic             carry_q;
  logic             carry_d;
  logic             at_zero_s;
  logic             at_max_s;

  // One step of a single stage, wrapping within 0..max.
  function automatic logic [WIDTH-1:0] step_wrap(input logic [WIDTH-1:0] v,
                                                 input logic [WIDTH-1:0] max,
                                                 input logic             up);
    logic [WIDTH-1:0] r;
    if (up) begin
      r = (v == max) ? '0 : v + ONE_W;
    end else begin
      r = (v == '0) ? max : v - ONE_W;
    end
    return r;
  endfunction

  // Load values above the stage terminal count are pinned to it.
  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v,
                                             input logic [WIDTH-1:0] max);
    return (v > max) ? max : v;
  endfunction

  // Unpack per-stage terminal counts.
  always_comb begin
    for (int i = 0; i < NUM_STAGES; i++) begin
      max_s[i] = MAX_VEC[WIDTH*i +: WIDTH];
    end
  end

  // Chain limit detection and packed output view.
  always_comb begin
    at_zero_s = 1'b1;
    at_max_s  = 1'b1;
    count     = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (cnt_q[i] != '0) begin
        at_zero_s = 1'b0;
      end else begin
        at_zero_s = at_zero_s;
      end
      if (cnt_q[i] != max_s[i]) begin
        at_max_s = 1'b0;
      end else begin
        at_max_s = at_max_s;
      end
      count[WIDTH*i +: WIDTH] = cnt_q[i];
    end
  end

  assign at_zero   = at_zero_s;
  assign at_max    = at_max_s;
  assign carry_out = carry_q;

  // Next-state: load > adjust > tick; idle holds.
  always_comb begin
    logic ripple;
    ripple  = 1'b1;
    carry_d = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      cnt_d[i] = cnt_q[i];
    end

    if (load) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        cnt_d[i] = clamp(load_val[WIDTH*i +: WIDTH], max_s[i]);
      end
    end else if (adj_en) begin
      // Out-of-range stage indices simply never match.
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (int'(adj_stage) == i) begin
          cnt_d[i] = step_wrap(cnt_q[i], max_s[i], up_down);
        end else begin
          cnt_d[i] = cnt_q[i];
        end
      end
    end else if (tick) begin
      if ((up_down && at_max_s) || (!up_down && at_zero_s)) begin
        carry_d = 1'b1;
        if (WRAP_MODE != 0) begin
          for (int i = 0; i < NUM_STAGES; i++) begin
            cnt_d[i] = up_down ? max_s[i] - max_s[i] : max_s[i];
          end
        end else begin
          for (int i = 0; i < NUM_STAGES; i++) begin
            cnt_d[i] = cnt_q[i];
          end
        end
      end else begin
        // A stage moves only while every lower stage sits at its rollover value.
        for (int i = 0; i < NUM_STAGES; i++) begin
          if (ripple) begin
            cnt_d[i] = step_wrap(cnt_q[i], max_s[i], up_down);
          end else begin
            cnt_d[i] = cnt_q[i];
          end
          if (up_down) begin
            ripple = ripple & (cnt_q[i] == max_s[i]);
          end else begin
            ripple = ripple & (cnt_q[i] == '0);
          end
        end
      end
    end else begin
      carry_d = 1'b0;
    end
  end

  // Stage and carry registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        cnt_q[i] <= '0;
      end
      carry_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      carry_q <= carry_d;
    end
  end

endmodule

// File: tb/tb_cascade_updown_timer.sv
// Directed self-checking bench for cascade_updown_timer (wrapping and saturating builds).
module tb_cascade_updown_timer;

  logic        clk;
  logic        reset;
  logic        tick;
  logic        up_down;
  logic        load;
  logic [17:0] load_val;
  logic        adj_en;
  logic [1:0]  adj_stage;

  logic [17:0] count_w, count_s;
  logic        carry_w, carry_s;
  logic        zero_w, zero_s;
  logic        max_w, max_s;

  int n_pass;
  int n_total;

  cascade_updown_timer #(.WRAP_MODE(1)) dut (
    .clk(clk), .reset(reset), .tick(tick), .up_down(up_down), .load(load),
    .load_val(load_val), .adj_en(adj_en), .adj_stage(adj_stage),
    .count(count_w), .carry_out(carry_w), .at_zero(zero_w), .at_max(max_w)
  );

  cascade_updown_timer #(.WRAP_MODE(0)) dut_sat (
    .clk(clk), .reset(reset), .tick(tick), .up_down(up_down), .load(load),
    .load_val(load_val), .adj_en(adj_en), .adj_stage(adj_stage),
    .count(count_s), .carry_out(carry_s), .at_zero(zero_s), .at_max(max_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] hms(input int h, input int m, input int s);
    logic [5:0] hh, mm, ss;
    hh = 6'(h);
    mm = 6'(m);
    ss = 6'(s);
    return {hh, mm, ss};
  endfunction

  task automatic do_tick(input logic ud);
    tick    = 1'b1;
    up_down = ud;
    @(negedge clk);
    tick    = 1'b0;
  endtask

  task automatic do_load(input logic [17:0] v);
    load     = 1'b1;
    load_val = v;
    @(negedge clk);
    load     = 1'b0;
  endtask

  task automatic do_adj(input logic [1:0] stg, input logic ud);
    adj_en    = 1'b1;
    adj_stage = stg;
    up_down   = ud;
    @(negedge clk);
    adj_en    = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1;
    n_total++; if (count_w !== 18'd0) $display("FAIL reset_count got %h want %h", count_w, 18'd0); else n_pass++;
    n_total++; if (carry_w !== 1'b0) $display("FAIL reset_carry got %b want 0", carry_w); else n_pass++;
    n_total++; if (zero_w !== 1'b1) $display("FAIL reset_at_zero got %b want 1", zero_w); else n_pass++;
    n_total++; if (max_w !== 1'b0) $display("FAIL reset_at_max got %b want 0", max_w); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_count_up;
    logic saw_carry;
    logic saw_60;
    saw_carry = 1'b0;
    saw_60    = 1'b0;
    for (int k = 0; k < 60; k++) begin
      do_tick(1'b1);
      saw_carry = saw_carry | carry_w;
      saw_60    = saw_60 | (count_w[5:0] == 6'd60);
      if (k == 29) begin
        n_total++; if (count_w !== hms(0, 0, 30)) $display("FAIL up_30 got %h want %h", count_w, hms(0, 0, 30)); else n_pass++;
      end
    end
    n_total++; if (count_w !== hms(0, 1, 0)) $display("FAIL up_60 got %h want %h", count_w, hms(0, 1, 0)); else n_pass++;
    n_total++; if (saw_carry !== 1'b0) $display("FAIL up_no_carry got %b want 0", saw_carry); else n_pass++;
    n_total++; if (saw_60 !== 1'b0) $display("FAIL up_no_sec60 got %b want 0", saw_60); else n_pass++;
    n_total++; if (zero_w !== 1'b0) $display("FAIL up_at_zero got %b want 0", zero_w); else n_pass++;
  endtask

  task automatic test_wrap_up;
    do_load(hms(23, 59, 59));
    n_total++; if (max_w !== 1'b1) $display("FAIL wrapup_at_max got %b want 1", max_w); else n_pass++;
    do_tick(1'b1);
    n_total++; if (count_w !== 18'd0) $display("FAIL wrapup_count got %h want 0", count_w); else n_pass++;
    n_total++; if (carry_w !== 1'b1) $display("FAIL wrapup_carry got %b want 1", carry_w); else n_pass++;
    n_total++; if (zero_w !== 1'b1) $display("FAIL wrapup_at_zero got %b want 1", zero_w); else n_pass++;
    @(negedge clk);
    n_total++; if (carry_w !== 1'b0) $display("FAIL wrapup_pulse_width got %b want 0", carry_w); else n_pass++;
  endtask

  task automatic test_wrap_down;
    do_tick(1'b0);
    n_total++; if (count_w !== hms(23, 59, 59)) $display("FAIL wrapdn_count got %h want %h", count_w, hms(23, 59, 59)); else n_pass++;
    n_total++; if (carry_w !== 1'b1) $display("FAIL wrapdn_carry got %b want 1", carry_w); else n_pass++;
    n_total++; if (max_w !== 1'b1) $display("FAIL wrapdn_at_max got %b want 1", max_w); else n_pass++;
    @(negedge clk);
    n_total++; if (carry_w !== 1'b0) $display("FAIL wrapdn_pulse_width got %b want 0", carry_w); else n_pass++;
    do_tick(1'b0);
    n_total++; if (count_w !== hms(23, 59, 58)) $display("FAIL down_step got %h want %h", count_w, hms(23, 59, 58)); else n_pass++;
    do_load(hms(5, 0, 0));
    do_tick(1'b0);
    n_total++; if (count_w !== hms(4, 59, 59)) $display("FAIL down_borrow got %h want %h", count_w, hms(4, 59, 59)); else n_pass++;
    n_total++; if (carry_w !== 1'b0) $display("FAIL down_borrow_carry got %b want 0", carry_w); else n_pass++;
  endtask

  task automatic test_saturate;
    do_load(hms(23, 59, 58));
    do_tick(1'b1);
    n_total++; if (count_s !== hms(23, 59, 59)) $display("FAIL sat_t1_count got %h want %h", count_s, hms(23, 59, 59)); else n_pass++;
    n_total++; if (carry_s !== 1'b0) $display("FAIL sat_t1_carry got %b want 0", carry_s); else n_pass++;
    do_tick(1'b1);
    n_total++; if (count_s !== hms(23, 59, 59)) $display("FAIL sat_t2_count got %h want %h", count_s, hms(23, 59, 59)); else n_pass++;
    n_total++; if (carry_s !== 1'b1) $display("FAIL sat_t2_carry got %b want 1", carry_s); else n_pass++;
    do_tick(1'b1);
    n_total++; if (count_s !== hms(23, 59, 59)) $display("FAIL sat_t3_count got %h want %h", count_s, hms(23, 59, 59)); else n_pass++;
    n_total++; if (carry_s !== 1'b1) $display("FAIL sat_t3_carry got %b want 1", carry_s); else n_pass++;
    @(negedge clk);
    n_total++; if (carry_s !== 1'b0) $display("FAIL sat_idle_carry got %b want 0", carry_s); else n_pass++;
    do_load(18'd0);
    do_tick(1'b0);
    n_total++; if (count_s !== 18'd0) $display("FAIL sat_down_count got %h want 0", count_s); else n_pass++;
    n_total++; if (carry_s !== 1'b1) $display("FAIL sat_down_carry got %b want 1", carry_s); else n_pass++;
  endtask

  task automatic test_adjust;
    do_load(hms(10, 59, 30));
    do_adj(2'd1, 1'b1);
    n_total++; if (count_w !== hms(10, 0, 30)) $display("FAIL adj_min_count got %h want %h", count_w, hms(10, 0, 30)); else n_pass++;
    n_total++; if (carry_w !== 1'b0) $display("FAIL adj_min_carry got %b want 0", carry_w); else n_pass++;
    do_adj(2'd3, 1'b1);
    n_total++; if (count_w !== hms(10, 0, 30)) $display("FAIL adj_oob got %h want %h", count_w, hms(10, 0, 30)); else n_pass++;
    do_adj(2'd2, 1'b0);
    n_total++; if (count_w !== hms(9, 0, 30)) $display("FAIL adj_hr_down got %h want %h", count_w, hms(9, 0, 30)); else n_pass++;
    do_adj(2'd1, 1'b0);
    n_total++; if (count_w !== hms(9, 59, 30)) $display("FAIL adj_min_wrap_down got %h want %h", count_w, hms(9, 59, 30)); else n_pass++;
  endtask

  task automatic test_priority;
    tick      = 1'b1;
    adj_en    = 1'b1;
    adj_stage = 2'd0;
    up_down   = 1'b1;
    do_load(hms(0, 0, 63));
    n_total++; if (count_w !== hms(0, 0, 59)) $display("FAIL prio_load got %h want %h", count_w, hms(0, 0, 59)); else n_pass++;
    n_total++; if (carry_w !== 1'b0) $display("FAIL prio_load_carry got %b want 0", carry_w); else n_pass++;
    // adjust still asserted with tick: seconds wrap alone, minutes untouched
    @(negedge clk);
    n_total++; if (count_w !== hms(0, 0, 0)) $display("FAIL prio_adj got %h want %h", count_w, hms(0, 0, 0)); else n_pass++;
    n_total++; if (carry_w !== 1'b0) $display("FAIL prio_adj_carry got %b want 0", carry_w); else n_pass++;
    tick   = 1'b0;
    adj_en = 1'b0;
    do_load(hms(30, 60, 61));
    n_total++; if (count_w !== hms(23, 59, 59)) $display("FAIL clamp_all got %h want %h", count_w, hms(23, 59, 59)); else n_pass++;
  endtask

  task automatic test_async_reset;
    do_load(hms(23, 59, 58));
    tick    = 1'b1;
    up_down = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_total++; if (carry_w !== 1'b1) $display("FAIL areset_pre_carry got %b want 1", carry_w); else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_total++; if (count_w !== 18'd0) $display("FAIL areset_count got %h want 0", count_w); else n_pass++;
    n_total++; if (carry_w !== 1'b0) $display("FAIL areset_carry got %b want 0", carry_w); else n_pass++;
    n_total++; if (zero_w !== 1'b1) $display("FAIL areset_at_zero got %b want 1", zero_w); else n_pass++;
    tick = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_total++; if (count_w !== 18'd0) $display("FAIL idle_hold got %h want 0", count_w); else n_pass++;
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    tick      = 1'b0;
    up_down   = 1'b1;
    load      = 1'b0;
    load_val  = 18'd0;
    adj_en    = 1'b0;
    adj_stage = 2'd0;
    test_reset();
    test_count_up();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_adjust();
    test_priority();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
